// File: rtl/fifo_rx_param.sv
// -----------------------------------------------------------------------------
// fifo_rx_param -- parametrised Zigbee RX buffer
//
// Purpose:
//   Collects the serial bit stream recovered by the CDR into DATA_W-bit words,
//   queues them in a DEPTH-entry FIFO, and exposes the FIFO together with
//   status, control, flush and sticky error flags through a zero-wait-state
//   APB register map.
//
// Register map (only paddr[1:0] is decoded):
//   0x0 DATA   RO   head word, pops on the access edge; error when empty or written
//   0x1 STATUS R/W1C [0] empty [1] full [2] ovf [3] udf [15:8] level
//   0x2 CTRL   RW   [0] en [1] flush (self-clearing) [2] msb
//                   [3] irq_en [11:8] thr   (FIFO_RX_IRQ_EN builds only)
//   0x3 --          always returns pslverr
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   en_cdr, data_in  CDR bit strobe and the bit it qualifies
//   psel, penable, pwrite, paddr, pwdata
//                    APB requester signals
//   prdata, pready, pslverr
//                    APB completer signals (valid in the access phase only)
//   mem_state        registered "FIFO holds at least one word"
//   irq              registered interrupt (only when FIFO_RX_IRQ_EN is defined)
//
// Build option:
//   FIFO_RX_IRQ_EN   adds the irq port and the CTRL irq_en/thr fields.
// -----------------------------------------------------------------------------
module fifo_rx_param #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int PADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en_cdr,
    input  logic               data_in,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [PADDR_W-1:0] paddr,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
`ifdef FIFO_RX_IRQ_EN
    output logic               irq,
`endif
    output logic               mem_state
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_addr_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [BC_W-1:0]   bitcnt;
    logic [DATA_W-1:0] shreg;
    logic              ovf, udf;
    logic              ctrl_en, ctrl_msb;

    // Next-state values
    logic [PW-1:0]     wptr_n, rptr_n, level_n;
    logic [BC_W-1:0]   bitcnt_n;
    logic [DATA_W-1:0] shreg_n;
    logic              ovf_n, udf_n, en_n, msb_n;

    // -------------------------------------------------------------------------
    // APB decode
    // -------------------------------------------------------------------------
    reg_addr_e addr;
    logic      access, rd_acc, wr_acc;
    logic      status_wr, ctrl_wr;

    assign addr      = reg_addr_e'(paddr[1:0]);
    assign access    = psel & penable;   // setup phase alone never has an effect
    assign rd_acc    = access & ~pwrite;
    assign wr_acc    = access & pwrite;
    assign status_wr = wr_acc & (addr == REG_STATUS);
    assign ctrl_wr   = wr_acc & (addr == REG_CTRL);
    assign pready    = access;

    // -------------------------------------------------------------------------
    // FIFO status
    // -------------------------------------------------------------------------
    logic [PW-1:0]     level;
    logic              empty, full;
    logic [DATA_W-1:0] head;

    assign level = wptr - rptr;
    assign empty = (level == '0);
    assign full  = (level == PW'(DEPTH));
    assign head  = mem[rptr[AW-1:0]];

    // -------------------------------------------------------------------------
    // Deserialiser
    // msb=0 shifts right and enters at the top, so after DATA_W bits the first
    // one sits in bit 0; msb=1 shifts left so the first bit ends in the MSB.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] din_vec, shifted;
    logic              strobe, word_done;

    assign din_vec   = DATA_W'(data_in);
    assign shifted   = ctrl_msb ? ((shreg << 1) | din_vec)
                                : ((shreg >> 1) | (din_vec << (DATA_W - 1)));
    assign strobe    = en_cdr & ctrl_en;
    assign word_done = strobe & (bitcnt == BC_W'(DATA_W - 1));

    // -------------------------------------------------------------------------
    // Push / pop / flush arbitration
    // -------------------------------------------------------------------------
    logic flush, pop, push_req, push, ovf_set, udf_set;

    assign flush    = ctrl_wr & pwdata[1];
    assign pop      = rd_acc & (addr == REG_DATA) & ~empty;
    assign udf_set  = rd_acc & (addr == REG_DATA) & empty;
    assign push_req = word_done & ~flush;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push     = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wptr_n   = wptr;
        rptr_n   = rptr;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        ovf_n    = ovf;
        udf_n    = udf;
        en_n     = ctrl_en;
        msb_n    = ctrl_msb;

        if (flush) begin
            wptr_n   = '0;
            rptr_n   = '0;
            bitcnt_n = '0;
            shreg_n  = '0;
        end else begin
            if (push) wptr_n = wptr + 1'b1;
            if (pop)  rptr_n = rptr + 1'b1;
            if (strobe) begin
                shreg_n  = shifted;
                bitcnt_n = word_done ? '0 : bitcnt + 1'b1;
            end
        end

        // Hardware set has priority over a simultaneous W1C.
        if (status_wr && pwdata[2]) ovf_n = 1'b0;
        if (status_wr && pwdata[3]) udf_n = 1'b0;
        if (ovf_set)                ovf_n = 1'b1;
        if (udf_set)                udf_n = 1'b1;

        if (ctrl_wr) begin
            en_n  = pwdata[0];
            msb_n = pwdata[2];
        end
    end

    assign level_n = wptr_n - rptr_n;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            ctrl_en   <= 1'b1;
            ctrl_msb  <= 1'b0;
            mem_state <= 1'b0;
        end else begin
            wptr      <= wptr_n;
            rptr      <= rptr_n;
            bitcnt    <= bitcnt_n;
            shreg     <= shreg_n;
            ovf       <= ovf_n;
            udf       <= udf_n;
            ctrl_en   <= en_n;
            ctrl_msb  <= msb_n;
            mem_state <= (level_n != '0);
        end
    end

    // NOTE: the storage array has no reset; the pointers define which entries
    // are valid, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= shifted;
    end

    // -------------------------------------------------------------------------
    // Optional interrupt
    // -------------------------------------------------------------------------
`ifdef FIFO_RX_IRQ_EN
    logic       irq_en, irq_en_n, irq_n;
    logic [3:0] thr, thr_n;

    always_comb begin
        irq_en_n = irq_en;
        thr_n    = thr;
        if (ctrl_wr) begin
            irq_en_n = pwdata[3];
            thr_n    = pwdata[11:8];
        end
        // Evaluated on next-state values so irq tracks the FIFO on the same edge.
        irq_n = irq_en_n & ((32'(level_n) >= 32'(thr_n)) | ovf_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
            thr    <= 4'd1;
            irq    <= 1'b0;
        end else begin
            irq_en <= irq_en_n;
            thr    <= thr_n;
            irq    <= irq_n;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Read-back words
    // -------------------------------------------------------------------------
    logic [31:0] status_word, ctrl_word;

    always_comb begin
        status_word       = '0;
        status_word[0]    = empty;
        status_word[1]    = full;
        status_word[2]    = ovf;
        status_word[3]    = udf;
        status_word[15:8] = 8'(level);

        ctrl_word         = '0;
        ctrl_word[0]      = ctrl_en;
        ctrl_word[2]      = ctrl_msb;   // flush (bit 1) always reads 0
`ifdef FIFO_RX_IRQ_EN
        ctrl_word[3]      = irq_en;
        ctrl_word[11:8]   = thr;
`endif
    end

    // prdata/pslverr are only driven during an access phase, zero otherwise.
    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (access && !reset) begin
            case (addr)
                REG_DATA: begin
                    if (pwrite || empty) pslverr = 1'b1;
                    else                 prdata  = 32'(head);
                end
                REG_STATUS: if (!pwrite) prdata = status_word;
                REG_CTRL:   if (!pwrite) prdata = ctrl_word;
                default:    pslverr = 1'b1;
            endcase
        end
    end

    // Undecoded address bits and unused write-data bits.
    logic unused_bits;
    assign unused_bits = ^{pwdata, paddr};

endmodule

// File: tb/tb_fifo_rx_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_rx_param -- self-checking bench for fifo_rx_param
//
// A queue-based reference model tracks stored words, the partial word, sticky
// flags and control fields. Directed scenarios cover the documented cases,
// then a randomized mix of bit strobes and APB accesses runs against the model.
// Build with FIFO_RX_IRQ_EN defined to also exercise the interrupt.
// -----------------------------------------------------------------------------
module tb_fifo_rx_param;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int PADDR_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               en_cdr;
    logic               data_in;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [PADDR_W-1:0] paddr;
    logic [31:0]        pwdata;
    logic [31:0]        prdata;
    logic               pready;
    logic               pslverr;
    logic               mem_state;
`ifdef FIFO_RX_IRQ_EN
    logic               irq;
`endif

    always #5 clk = ~clk;

    fifo_rx_param #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .PADDR_W (PADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en_cdr    (en_cdr),
        .data_in   (data_in),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
`ifdef FIFO_RX_IRQ_EN
        .irq       (irq),
`endif
        .mem_state (mem_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] q[$];
    logic [31:0]       part;
    int                part_cnt;
    logic              m_ovf, m_udf, m_en, m_msb;
    logic              m_irq_en;
    logic [3:0]        m_thr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic model_reset();
        q.delete();
        part     = '0;
        part_cnt = 0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        m_en     = 1'b1;
        m_msb    = 1'b0;
        m_irq_en = 1'b0;
        m_thr    = 4'd1;
    endtask

    // One received bit: the n-th bit of a word goes to position n (msb=0)
    // or DATA_W-1-n (msb=1); a completed word joins the queue if there is room.
    task automatic model_bit(input logic b, input logic en_v, input logic msb_v);
        if (!en_v) return;
        if (b) part = part | (32'd1 << (msb_v ? (DATA_W - 1 - part_cnt) : part_cnt));
        part_cnt++;
        if (part_cnt == DATA_W) begin
            if (q.size() < DEPTH) q.push_back(DATA_W'(part));
            else                  m_ovf = 1'b1;
            part     = '0;
            part_cnt = 0;
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s       = '0;
        s[0]    = (q.size() == 0);
        s[1]    = (q.size() == DEPTH);
        s[2]    = m_ovf;
        s[3]    = m_udf;
        s[15:8] = 8'(q.size());
        return s;
    endfunction

    function automatic logic [31:0] m_ctrl();
        logic [31:0] c;
        c    = '0;
        c[0] = m_en;
        c[2] = m_msb;
`ifdef FIFO_RX_IRQ_EN
        c[3]    = m_irq_en;
        c[11:8] = m_thr;
`endif
        return c;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_mem_state"}, 32'(mem_state), 32'(q.size() != 0));
`ifdef FIFO_RX_IRQ_EN
        check({tag, "_irq"}, 32'(irq),
              32'(m_irq_en && ((q.size() >= int'(m_thr)) || m_ovf)));
`endif
    endtask

    // ---------------- drivers (entered/left at posedge+1) ----------------
    task automatic idle_inputs();
        en_cdr  = 1'b0;
        data_in = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        check("rst_outputs", {prdata[29:0], pready, pslverr}, 32'd0);
        check_state("rst");
    endtask

    task automatic send_bit(input logic b);
        en_cdr  = 1'b1;
        data_in = b;
        @(posedge clk);
        model_bit(b, m_en, m_msb);
        #1;
        en_cdr  = 1'b0;
        data_in = 1'b0;
        check_state("bit");
    endtask

    // Bits go out w[0] first.
    task automatic send_word(input logic [DATA_W-1:0] w);
        for (int i = 0; i < DATA_W; i++) send_bit(w[i]);
    endtask

    // Full APB transfer; optionally a CDR strobe coincides with the access edge.
    task automatic apb(input logic wr, input logic [1:0] a, input logic [31:0] wd,
                       input logic cdr, input logic b, output logic [31:0] rd);
        logic [PADDR_W-1:0] pa;
        logic [31:0]        exp_rd;
        logic               exp_err, was_empty, old_en, old_msb, fl;
        pa      = PADDR_W'($urandom);
        pa[1:0] = a;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = pa;
        pwdata  = wd;
        #1;
        check("setup_prdata", prdata, 32'd0);
        check("setup_ready_err", {30'd0, pready, pslverr}, 32'd0);
        @(posedge clk);
        #1;
        penable   = 1'b1;
        en_cdr    = cdr;
        data_in   = b;
        was_empty = (q.size() == 0);
        exp_rd    = '0;
        exp_err   = 1'b0;
        case (a)
            2'd0:    if (wr || was_empty) exp_err = 1'b1; else exp_rd = 32'(q[0]);
            2'd1:    if (!wr) exp_rd = m_status();
            2'd2:    if (!wr) exp_rd = m_ctrl();
            default: exp_err = 1'b1;
        endcase
        #1;
        rd = prdata;
        check("pready", 32'(pready), 32'd1);
        check($sformatf("prdata_a%0d_w%0d", a, wr), prdata, exp_rd);
        check($sformatf("pslverr_a%0d_w%0d", a, wr), 32'(pslverr), 32'(exp_err));
        @(posedge clk);
        old_en  = m_en;
        old_msb = m_msb;
        fl      = 1'b0;
        if (!wr && a == 2'd0) begin
            if (was_empty) m_udf = 1'b1;
            else           void'(q.pop_front());
        end
        if (wr && a == 2'd1) begin
            if (wd[2]) m_ovf = 1'b0;
            if (wd[3]) m_udf = 1'b0;
        end
        if (wr && a == 2'd2) begin
            m_en  = wd[0];
            m_msb = wd[2];
            m_irq_en = wd[3];
            m_thr    = wd[11:8];
            if (wd[1]) begin
                fl = 1'b1;
                q.delete();
                part     = '0;
                part_cnt = 0;
            end
        end
        if (cdr && !fl) model_bit(b, old_en, old_msb);
        #1;
        idle_inputs();
        check_state("apb");
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] rd);
        apb(1'b0, a, 32'd0, 1'b0, 1'b0, rd);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        apb(1'b1, a, wd, 1'b0, 1'b0, dummy);
    endtask

    // Watchdog: the bench never waits on DUT handshakes, but stay bounded.
    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        logic [31:0]       rd, wd;
        logic [DATA_W-1:0] words [17];
        int                op, bit_pct;

        idle_inputs();
        reset = 1'b1;
        #1;
        do_reset();

        // 1: lsb-first word
        rd_reg(2'd1, rd);
        check("t1_status_reset", rd, 32'h0000_0001);
        rd_reg(2'd2, rd);
`ifdef FIFO_RX_IRQ_EN
        check("t1_ctrl_reset", rd, 32'h0000_0101);
`else
        check("t1_ctrl_reset", rd, 32'h0000_0001);
`endif
        send_word(8'h4D);
        check("t1_mem_state_set", 32'(mem_state), 32'd1);
        rd_reg(2'd0, rd);
        check("t1_data", rd, 32'h4D);
        check("t1_mem_state_clr", 32'(mem_state), 32'd0);

        // 2: msb-first word
        wr_reg(2'd2, 32'h5);
        send_word(8'h4D);
        rd_reg(2'd0, rd);
        check("t2_data_msb", rd, 32'hB2);
        wr_reg(2'd2, 32'h1);

        // 3: overflow
        for (int i = 0; i < 17; i++) begin
            words[i] = DATA_W'($urandom);
            send_word(words[i]);
        end
        rd_reg(2'd1, rd);
        check("t3_status_full", rd, 32'h0000_1006);
        for (int i = 0; i < 16; i++) begin
            rd_reg(2'd0, rd);
            check($sformatf("t3_order%0d", i), rd, 32'(words[i]));
        end
        wr_reg(2'd1, 32'h4);
        rd_reg(2'd1, rd);
        check("t3_ovf_cleared", rd, 32'h0000_0001);

        // 4: underflow, bad accesses
        rd_reg(2'd0, rd);
        check("t4_empty_read", rd, 32'd0);
        rd_reg(2'd1, rd);
        check("t4_udf", rd, 32'h0000_0009);
        rd_reg(2'd3, rd);
        wr_reg(2'd3, 32'hFFFF_FFFF);
        wr_reg(2'd0, 32'h0000_00FF);
        wr_reg(2'd1, 32'h8);

        // 5: full FIFO, push and pop on the same edge
        for (int i = 0; i < 16; i++) begin
            words[i] = DATA_W'($urandom);
            send_word(words[i]);
        end
        words[16] = DATA_W'($urandom);
        for (int i = 0; i < DATA_W - 1; i++) send_bit(words[16][i]);
        apb(1'b0, 2'd0, 32'd0, 1'b1, words[16][DATA_W-1], rd);
        check("t5_pop_head", rd, 32'(words[0]));
        rd_reg(2'd1, rd);
        check("t5_status", rd, 32'h0000_1002);
        for (int i = 1; i < 17; i++) begin
            rd_reg(2'd0, rd);
            check($sformatf("t5_order%0d", i), rd, 32'(words[i]));
        end

        // 6: flush with a partial word pending
        for (int i = 0; i < 3; i++) send_word(DATA_W'($urandom));
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        wr_reg(2'd2, 32'h3);
        rd_reg(2'd1, rd);
        check("t6_flushed", rd, 32'h0000_0001);
        send_word(8'hA5);
        rd_reg(2'd0, rd);
        check("t6_fresh_word", rd, 32'hA5);
`ifdef FIFO_RX_IRQ_EN
        wr_reg(2'd2, 32'h209);
        send_word(8'h11);
        check("t6_irq_below_thr", 32'(irq), 32'd0);
        send_word(8'h22);
        check("t6_irq_at_thr", 32'(irq), 32'd1);
        rd_reg(2'd0, rd);
        rd_reg(2'd0, rd);
        wr_reg(2'd2, 32'h101);
`endif

        // Reset mid-frame drops the partial word
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        do_reset();
        send_word(8'h3C);
        rd_reg(2'd0, rd);
        check("rst_midframe_word", rd, 32'h3C);

        // Disabled receiver holds the partial word
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        wr_reg(2'd2, 32'h0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        wr_reg(2'd2, 32'h1);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        rd_reg(2'd0, rd);
        check("en_hold_word", rd, 32'h07);

        // Randomized mix: bit-heavy first (fills/overflows), read-heavy later
        for (int it = 0; it < 800; it++) begin
            bit_pct = (it < 400) ? 80 : 35;
            op = $urandom_range(0, 99);
            if (op < bit_pct) begin
                send_bit(1'($urandom));
            end else begin
                op = $urandom_range(0, 99);
                if (op < 45) begin
                    apb(1'b0, 2'd0, 32'd0, 1'($urandom), 1'($urandom), rd);
                end else if (op < 60) begin
                    rd_reg(2'd1, rd);
                end else if (op < 68) begin
                    rd_reg(2'd2, rd);
                end else if (op < 78) begin
                    apb(1'b1, 2'd1, $urandom, 1'($urandom), 1'($urandom), rd);
                end else if (op < 88) begin
                    wd    = $urandom;
                    wd[0] = ($urandom_range(0, 7) != 0);
                    wd[1] = ($urandom_range(0, 5) == 0);
                    // Word layout changes only take effect cleanly across a flush.
                    if (wd[2] != m_msb) wd[1] = 1'b1;
                    apb(1'b1, 2'd2, wd, 1'($urandom), 1'($urandom), rd);
                end else if (op < 94) begin
                    apb(1'($urandom), 2'd3, $urandom, 1'($urandom), 1'($urandom), rd);
                end else begin
                    apb(1'b1, 2'd0, $urandom, 1'($urandom), 1'($urandom), rd);
                end
            end
        end
        rd_reg(2'd1, rd);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
